seq_mult_unit: RTL and testbench
================================

# seq_mult_unit

Parametrised sequential shift-add multiplier: controller and datapath in one block, the next generation of the fixed-width multiplier control unit driven by the debounced push-button pulses. It accepts two WIDTH-bit operands on a start pulse and handles signed or unsigned operands. It terminates early once the remaining multiplier bits are all zero. It reports the product, a one-cycle done pulse and the iteration count to the display logic.

## Interface
- WIDTH, 8: operand width in bits; must be ≥2; product is 2*WIDTH.
- EARLY_EXIT, 1: 1 = stop iterating when the shifted multiplier becomes zero; 0 = always WIDTH iterations.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- start  in  1  one-cycle pulse (typically debounced BTNC); sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands/product; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- product  out  2*WIDTH  result; valid from done, held until the next accepted start.
- busy  out  1  high from the cycle after an accepted start until done falls.
- done  out  1  one-cycle pulse, product valid.
- iterations  out  $clog2(WIDTH+1)  number of RUN cycles used by the last operation.

## Operation
- States: IDLE, RUN, SIGN, DONE.
- Reset: state IDLE. product, busy, done and iterations are 0. All internal registers are cleared.
- IDLE, start=1: capture the operands into the datapath and go to RUN.
  - If signed_mode: mag_a = |a|, mag_b = |b|, neg = a[W-1]^b[W-1]. Otherwise use a and b as-is and set neg = 0.
  - acc = 0; mcand = zero-extended mag_a (2*WIDTH bits); mplier = mag_b; count = 0.
- RUN, each cycle:
  - If mplier[0]: acc += mcand (2*WIDTH-bit add, no overflow possible).
  - mcand <<= 1; mplier >>= 1; count += 1.
  - Exit to SIGN when count reaches WIDTH, or when EARLY_EXIT and the shifted mplier == 0.
- SIGN: product = neg ? -acc : acc (2*WIDTH-bit two's complement); iterations = count. Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- The most negative operand −2^(W-1) has magnitude 2^(W-1). This fits the unsigned WIDTH-bit magnitude, so no special case is needed.
- start is ignored outside IDLE. start coincident with reset is ignored.
- A zero multiplier still executes one RUN cycle: iterations=1, product=0. A zero product with neg=1 yields 0.
- Reset in any state aborts the operation immediately. The next cycle is IDLE with all outputs at reset values.
- busy = (state != IDLE). busy is therefore high during DONE.

## Timing
- start accepted at edge e0.
- k RUN cycles occupy edges e1..ek. k = WIDTH, or with EARLY_EXIT the index of the highest set bit of mag_b plus 1, minimum 1.
- SIGN at edge e(k+1) registers product and iterations.
- done is high in the cycle following e(k+1). Latency from the start edge is k+2 cycles.
- The earliest next start is accepted at the edge that ends DONE+1, i.e. in IDLE one cycle after done.
- product changes only at the SIGN edge and on reset.

## Structure
- Shared package mult_pkg:
  - the state enum (IDLE, RUN, SIGN, DONE);
  - a count-width function $clog2(WIDTH+1) helper.
- Sub-module seq_mult_datapath holds acc, mcand, mplier, count and neg, plus the magnitude/negate logic. It takes load, step and fix controls from the FSM and returns a last flag.
- Push-button debouncing stays outside this block.

## Test plan
- WIDTH=8, EARLY_EXIT=1, unsigned, a=13, b=11 -> product=16'h008F (143), iterations=4, done exactly 6 cycles after the start edge, busy high for 6 cycles.
- Signed, a=8'hF9 (−7), b=5 -> product=16'hFFDD (−35), iterations=3. Signed, a=b=8'h80 -> product=16'h4000, iterations=8.
- b=0 with a=8'hFF, both modes -> product=0, iterations=1, done 3 cycles after start. EARLY_EXIT=0, a=b=8'hFF unsigned -> product=16'hFE01, iterations=8, latency 10.
- start pulsed during RUN with different operands -> ignored, the original product is delivered, exactly one done pulse.
- reset asserted in the 2nd RUN cycle -> next cycle is IDLE with product=0, done=0, busy=0, iterations=0. A subsequent start with 3*4 -> 12.
- WIDTH=16, signed, a=16'h8000, b=16'h7FFF -> product=32'hC0008000, iterations=15.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bits needed to hold an iteration count from 0 up to width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: magnitude capture, accumulate/shift steps and signed fix-up.
module seq_mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  parameter int CW         = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               fix_i,
  input  logic               signed_mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic [CW-1:0]      iterations_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      iter_q, iter_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mag_a, mag_b;

  // The most negative value negates to itself, which is already its unsigned magnitude.
  always_comb begin
    mag_a = (signed_mode_i && a_i[WIDTH-1]) ? -a_i : a_i;
    mag_b = (signed_mode_i && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;
    iter_d    = iter_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      count_d  = '0;
      neg_d    = signed_mode_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
    end else if (fix_i) begin
      product_d = neg_q ? -acc_q : acc_q;
      iter_d    = count_q;
    end
  end

  // Evaluated on the current step: true when this step is the final one.
  assign last_o = (count_q + CW'(1) == CW'(WIDTH)) ||
                  ((EARLY_EXIT != 0) && (mplier_q[WIDTH-1:1] == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      iter_q    <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      iter_q    <= iter_d;
    end
  end

  assign product_o    = product_q;
  assign iterations_o = iter_q;

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential signed/unsigned multiplier: IDLE/RUN/SIGN/DONE controller around the datapath.
module seq_mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        signed_mode,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic [2*WIDTH-1:0]          product,
  output logic                        busy,
  output logic                        done,
  output logic [cnt_width(WIDTH)-1:0] iterations
);

  localparam int CW = cnt_width(WIDTH);

  state_e state_q, state_d;
  logic   load, step, fix, last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = SIGN;
      SIGN:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load = (state_q == IDLE) && start;
    step = (state_q == RUN);
    fix  = (state_q == SIGN);
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  seq_mult_datapath #(
    .WIDTH     (WIDTH),
    .EARLY_EXIT(EARLY_EXIT),
    .CW        (CW)
  ) u_datapath (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .step_i       (step),
    .fix_i        (fix),
    .signed_mode_i(signed_mode),
    .a_i          (a),
    .b_i          (b),
    .last_o       (last),
    .product_o    (product),
    .iterations_o (iterations)
  );

endmodule

// File: tb/tb_seq_mult_unit.sv
// Three multiplier configurations driven in lockstep and checked every cycle against a timeline model.
module tb_seq_mult_unit;

  localparam int NI = 3;  // 0: W8 early exit, 1: W8 full, 2: W16 early exit

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] a_s = '0;
  logic [15:0] b_s = '0;

  logic [31:0] dut_prod [NI];
  logic [31:0] dut_iter [NI];
  logic        dut_busy [NI];
  logic        dut_done [NI];

  int checks = 0;
  int errors = 0;
  int ndone [NI] = '{0, 0, 0};
  int lat   [NI] = '{0, 0, 0};

  always #5 clk = ~clk;

  genvar gi;
  for (gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W  = (gi == 2) ? 16 : 8;
    localparam int EE = (gi == 1) ? 0 : 1;
    logic [2*W-1:0]          prod;
    logic [$clog2(W+1)-1:0]  iter;
    logic                    bz, dn;
    seq_mult_unit #(.WIDTH(W), .EARLY_EXIT(EE)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .signed_mode(signed_mode),
      .a          (a_s[W-1:0]),
      .b          (b_s[W-1:0]),
      .product    (prod),
      .busy       (bz),
      .done       (dn),
      .iterations (iter)
    );
    assign dut_prod[gi] = 32'(prod);
    assign dut_iter[gi] = 32'(iter);
    assign dut_busy[gi] = bz;
    assign dut_done[gi] = dn;
  end

  function automatic int cfg_w(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic int cfg_ee(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  // Expected product from plain integer arithmetic and expected iteration count.
  function automatic void calc(input int w, input int ee, input logic [15:0] av,
                               input logic [15:0] bv, input logic sm,
                               output logic [31:0] p, output int k);
    longint m, ua, ub, sa, sb, mb, full;
    m  = (longint'(1) << w) - 1;
    ua = longint'(av) & m;
    ub = longint'(bv) & m;
    sa = ua;
    sb = ub;
    if (sm) begin
      if (ua >= (longint'(1) << (w - 1))) sa = ua - (longint'(1) << w);
      if (ub >= (longint'(1) << (w - 1))) sb = ub - (longint'(1) << w);
    end
    mb   = (sb < 0) ? -sb : sb;
    full = sa * sb;
    p    = 32'(full & ((longint'(1) << (2 * w)) - 1));
    k    = w;
    if (ee != 0) begin
      k = 1;
      for (int i = 0; i < w; i++) if (mb[i]) k = i + 1;
    end
  endfunction

  // Model: t = cycles since the accepting edge (0 = idle); busy for k+2 cycles, done on the last.
  int          t     [NI] = '{0, 0, 0};
  int          rk    [NI] = '{0, 0, 0};
  logic [31:0] rp    [NI] = '{0, 0, 0};
  logic [31:0] eprod [NI] = '{0, 0, 0};
  int          eiter [NI] = '{0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        t[i]     = 0;
        eprod[i] = '0;
        eiter[i] = 0;
      end else if (t[i] == 0) begin
        if (start) begin
          calc(cfg_w(i), cfg_ee(i), a_s, b_s, signed_mode, rp[i], rk[i]);
          t[i] = 1;
        end
      end else if (t[i] == rk[i] + 2) begin
        t[i] = 0;
      end else begin
        t[i] = t[i] + 1;
        if (t[i] == rk[i] + 2) begin
          eprod[i] = rp[i];
          eiter[i] = rk[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, idx, $time, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare every instance with the model.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("busy", i, 32'(dut_busy[i]), 32'(t[i] != 0));
      chk("done", i, 32'(dut_done[i]), 32'((t[i] != 0) && (t[i] == rk[i] + 2)));
      chk("product", i, dut_prod[i], eprod[i]);
      chk("iterations", i, dut_iter[i], 32'(eiter[i]));
      if (dut_done[i]) ndone[i]++;
    end
  endtask

  // Start one operation; optionally pulse start again (with new operands) n cycles in.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                        input int glitch_at);
    a_s = av;
    b_s = bv;
    signed_mode = sm;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_s = 16'($urandom);
    b_s = 16'($urandom);
    signed_mode = 1'($urandom);
    lat = '{0, 0, 0};
    for (int n = 1; n <= 40; n++) begin
      for (int i = 0; i < NI; i++) if (lat[i] == 0 && dut_done[i]) lat[i] = n;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      start = (n == glitch_at);
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < NI; i++) begin
      if (lat[i] == 0) begin
        checks++;
        errors++;
        $display("FAIL done_timeout[%0d]: no done within 40 cycles", i);
      end
    end
    tick();
  endtask

  int nd0 [NI];

  initial begin
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("reset_product", i, dut_prod[i], 32'h0);
      chk("reset_busy", i, 32'(dut_busy[i]), 32'h0);
    end
    reset = 1'b0;
    tick();

    run_op(16'd13, 16'd11, 1'b0, 0);
    chk("lit_13x11_prod", 0, dut_prod[0], 32'h008F);
    chk("lit_13x11_iter", 0, dut_iter[0], 32'd4);
    chk("lit_13x11_lat", 0, 32'(lat[0]), 32'd6);

    run_op(16'h00F9, 16'h0005, 1'b1, 0);
    chk("lit_m7x5_prod", 0, dut_prod[0], 32'hFFDD);
    chk("lit_m7x5_iter", 0, dut_iter[0], 32'd3);

    run_op(16'h0080, 16'h0080, 1'b1, 0);
    chk("lit_80x80_prod", 0, dut_prod[0], 32'h4000);
    chk("lit_80x80_iter", 0, dut_iter[0], 32'd8);

    for (int m = 0; m < 2; m++) begin
      run_op(16'h00FF, 16'h0000, 1'(m), 0);
      chk("lit_bzero_prod", 0, dut_prod[0], 32'h0);
      chk("lit_bzero_iter", 0, dut_iter[0], 32'd1);
      chk("lit_bzero_lat", 0, 32'(lat[0]), 32'd3);
    end

    run_op(16'h00FF, 16'h00FF, 1'b0, 0);
    chk("lit_ee0_prod", 1, dut_prod[1], 32'hFE01);
    chk("lit_ee0_iter", 1, dut_iter[1], 32'd8);
    chk("lit_ee0_lat", 1, 32'(lat[1]), 32'd10);

    run_op(16'h8000, 16'h7FFF, 1'b1, 0);
    chk("lit_w16_prod", 2, dut_prod[2], 32'hC0008000);
    chk("lit_w16_iter", 2, dut_iter[2], 32'd15);

    // Start pulse during RUN must be ignored by every configuration.
    nd0 = ndone;
    run_op(16'd100, 16'd77, 1'b0, 2);
    for (int n = 0; n < 12; n++) tick();
    chk("lit_glitch_prod", 0, dut_prod[0], 32'd7700);
    for (int i = 0; i < NI; i++) chk("glitch_done_pulses", i, 32'(ndone[i] - nd0[i]), 32'd1);

    // Reset in the second RUN cycle aborts back to idle with cleared outputs.
    a_s = 16'h00FF;
    b_s = 16'h00FF;
    signed_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < NI; i++) begin
      chk("abort_product", i, dut_prod[i], 32'h0);
      chk("abort_iter", i, dut_iter[i], 32'h0);
      chk("abort_busy", i, 32'(dut_busy[i]), 32'h0);
      chk("abort_done", i, 32'(dut_done[i]), 32'h0);
    end
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("start_with_reset_busy", 0, 32'(dut_busy[0]), 32'h0);
    run_op(16'd3, 16'd4, 1'b0, 0);
    chk("lit_3x4_prod", 0, dut_prod[0], 32'd12);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) ra = 16'h8080;
      if ($urandom_range(0, 7) == 0) rb = 16'hFF80;
      run_op(ra, rb, 1'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
